// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM and the ALU control decoder.
// Optional macro JUMP_EN adds the JUMP/JUMP_R states.
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_LUI = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_LOAD_WB  = 4'd9,
`ifdef JUMP_EN
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JUMP_R   = 4'd12
`else
    S_BRANCH   = 4'd10
`endif
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_OP_W-1:0] ALU_OP_R   = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LUI = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BR  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_JAL = 3'b101;

  localparam logic [SEL_W-1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_IMM = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_ALU = 2'b10;

  localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WB_MEM = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_LUI, CLS_BRANCH, CLS_JAL, CLS_JALR
  } instr_class_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_b;
    logic                mem_read;
    logic                mem_write;
    logic                i_or_d;
    logic                ir_write;
    logic                pc_write;
    logic                branch;
    logic [SEL_W-1:0]    pc_src;
    logic                reg_write;
    logic [SEL_W-1:0]    mem_to_reg;
    logic                illegal;
  } ctrl_t;

  // Quiescent control word: every enable low, ALU in add mode.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_OP_ADD;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_classifier.sv
// Combinational opcode-to-instruction-class map with an illegal flag.
// JAL/JALR are legal only when JUMP_EN is defined.
module opcode_classifier
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        instr_class_c,
  output logic                illegal_c
);

  always_comb begin
    instr_class_c = CLS_I;
    illegal_c     = 1'b0;
    case (opcode)
      OP_R:      instr_class_c = CLS_R;
      OP_I:      instr_class_c = CLS_I;
      OP_LW:     instr_class_c = CLS_LOAD;
      OP_SW:     instr_class_c = CLS_STORE;
      OP_LUI:    instr_class_c = CLS_LUI;
      OP_BRANCH: instr_class_c = CLS_BRANCH;
`ifdef JUMP_EN
      OP_JAL:    instr_class_c = CLS_JAL;
      OP_JALR:   instr_class_c = CLS_JALR;
`endif
      default:   illegal_c     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle RISC-V datapath (fetch/decode/execute/memory/write-back).
// Define JUMP_EN to decode JAL/JALR; otherwise they take the illegal path.
module multicycle_control_unit
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output logic [ALU_OP_W-1:0] ALU_Op_o,
  output logic                ALU_Src_B_o,
  output logic                Mem_Read_o,
  output logic                Mem_Write_o,
  output logic                I_or_D_o,
  output logic                IR_Write_o,
  output logic                PC_Write_o,
  output logic                Branch_o,
  output logic [SEL_W-1:0]    PC_Src_o,
  output logic                Reg_Write_o,
  output logic [SEL_W-1:0]    Mem_to_Reg_o,
  output logic                Illegal_o
);

  state_t              state, next_state;
  ctrl_t               ctrl, ctrl_out;
  instr_class_t        instr_class_c;
  logic                illegal_c;
  logic [ALU_OP_W-1:0] hold_op;
  logic                hold_src;

  opcode_classifier u_classifier (
    .opcode        (opcode_i),
    .instr_class_c (instr_class_c),
    .illegal_c     (illegal_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // ALU_WB repeats the ALU controls of the execute state that preceded it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_op  <= ALU_OP_ADD;
      hold_src <= 1'b0;
    end else if (state == S_EXEC_R || state == S_EXEC_I || state == S_EXEC_LUI) begin
      hold_op  <= ctrl.alu_op;
      hold_src <= ctrl.alu_src_b;
    end
  end

  always_comb begin
    next_state = state;
    ctrl       = ctrl_idle();
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready_i;
        ctrl.pc_write = mem_ready_i;
        ctrl.pc_src   = PC_SRC_PC4;
        if (mem_ready_i) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (illegal_c) begin
          ctrl.illegal = 1'b1;
          next_state   = S_FETCH;
        end else begin
          case (instr_class_c)
            CLS_R:             next_state = S_EXEC_R;
            CLS_I:             next_state = S_EXEC_I;
            CLS_LOAD, CLS_STORE: next_state = S_MEM_ADDR;
            CLS_LUI:           next_state = S_EXEC_LUI;
            CLS_BRANCH:        next_state = S_BRANCH;
`ifdef JUMP_EN
            CLS_JAL:           next_state = S_JUMP;
            CLS_JALR:          next_state = S_JUMP_R;
`endif
            default:           next_state = S_FETCH;
          endcase
        end
      end
      S_EXEC_R: begin
        ctrl.alu_op = ALU_OP_R;
        next_state  = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctrl.alu_src_b = 1'b1;
        next_state     = S_ALU_WB;
      end
      S_EXEC_LUI: begin
        ctrl.alu_op    = ALU_OP_LUI;
        ctrl.alu_src_b = 1'b1;
        next_state     = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.alu_op     = hold_op;
        ctrl.alu_src_b  = hold_src;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_ALU;
        next_state      = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_b = 1'b1;
        next_state     = (instr_class_c == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.alu_src_b = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = 1'b1;
        if (mem_ready_i) next_state = S_LOAD_WB;
      end
      S_MEM_WR: begin
        ctrl.alu_src_b = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready_i) next_state = S_FETCH;
      end
      S_LOAD_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_MEM;
        next_state      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_op = ALU_OP_BR;
        ctrl.branch = 1'b1;
        ctrl.pc_src = PC_SRC_IMM;
        next_state  = S_FETCH;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        ctrl.alu_op     = ALU_OP_JAL;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_IMM;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC4;
        next_state      = S_FETCH;
      end
      S_JUMP_R: begin
        ctrl.alu_src_b  = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_ALU;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC4;
        next_state      = S_FETCH;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  // Reset blanks every output at once, Mealy terms included.
  assign ctrl_out = reset ? ctrl : '0;

  assign ALU_Op_o     = ctrl_out.alu_op;
  assign ALU_Src_B_o  = ctrl_out.alu_src_b;
  assign Mem_Read_o   = ctrl_out.mem_read;
  assign Mem_Write_o  = ctrl_out.mem_write;
  assign I_or_D_o     = ctrl_out.i_or_d;
  assign IR_Write_o   = ctrl_out.ir_write;
  assign PC_Write_o   = ctrl_out.pc_write;
  assign Branch_o     = ctrl_out.branch;
  assign PC_Src_o     = ctrl_out.pc_src;
  assign Reg_Write_o  = ctrl_out.reg_write;
  assign Mem_to_Reg_o = ctrl_out.mem_to_reg;
  assign Illegal_o    = ctrl_out.illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected control words from an instruction-level model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       src_b, rd, wr, iord, irw, pcw, br, rw, ill;
  logic [1:0] pcs, m2r;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode),
    .mem_ready_i  (mem_ready),
    .ALU_Op_o     (alu_op),
    .ALU_Src_B_o  (src_b),
    .Mem_Read_o   (rd),
    .Mem_Write_o  (wr),
    .I_or_D_o     (iord),
    .IR_Write_o   (irw),
    .PC_Write_o   (pcw),
    .Branch_o     (br),
    .PC_Src_o     (pcs),
    .Reg_Write_o  (rw),
    .Mem_to_Reg_o (m2r),
    .Illegal_o    (ill)
  );

  wire [15:0] act = {alu_op, src_b, rd, wr, iord, irw, pcw, br, pcs, rw, m2r, ill};

  logic [15:0] exp_q[$];
  string       name_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] v(input logic [2:0] op, input logic sb, input logic r,
                                    input logic w, input logic io, input logic ir, input logic pw,
                                    input logic b, input logic [1:0] ps, input logic regw,
                                    input logic [1:0] wb, input logic il);
    return {op, sb, r, w, io, ir, pw, b, ps, regw, wb, il};
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    case (o)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b1100011: return 1'b1;
`ifdef JUMP_EN
      7'b1101111, 7'b1100111: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, e, $time);
    end
  endtask

  // One clock of stimulus plus the control word the model expects during it.
  task automatic drive(input logic [6:0] opc, input logic rdy, input logic [15:0] e, input string nm);
    @(posedge clk);
    #1;
    opcode    = opc;
    mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check(name_q.pop_front(), exp_q.pop_front());
    end
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw);
    for (int i = 0; i < fw; i++)
      drive(opc, 1'b0, v(3'b001, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "fetch_wait");
    drive(opc, 1'b1, v(3'b001, 0, 1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 0), "fetch");
    drive(opc, rnd(), v(3'b001, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, !is_legal(opc)), "decode");
    if (!is_legal(opc)) return;
    case (opc)
      7'b0110011: begin
        drive(opc, rnd(), v(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "exec_r");
        drive(opc, rnd(), v(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0), "wb_r");
      end
      7'b0010011: begin
        drive(opc, rnd(), v(3'b001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "exec_i");
        drive(opc, rnd(), v(3'b001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0), "wb_i");
      end
      7'b0110111: begin
        drive(opc, rnd(), v(3'b010, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "exec_lui");
        drive(opc, rnd(), v(3'b010, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0), "wb_lui");
      end
      7'b0000011: begin
        drive(opc, rnd(), v(3'b001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "addr_lw");
        for (int i = 0; i <= mw; i++)
          drive(opc, 1'(i == mw), v(3'b001, 1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0), "mem_rd");
        drive(opc, rnd(), v(3'b001, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 0), "load_wb");
      end
      7'b0100011: begin
        drive(opc, rnd(), v(3'b001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "addr_sw");
        for (int i = 0; i <= mw; i++)
          drive(opc, 1'(i == mw), v(3'b001, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0), "mem_wr");
      end
      7'b1100011:
        drive(opc, rnd(), v(3'b100, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0), "branch");
      7'b1101111:
        drive(opc, rnd(), v(3'b101, 0, 0, 0, 0, 0, 1, 0, 2'b01, 1, 2'b10, 0), "jal");
      7'b1100111:
        drive(opc, rnd(), v(3'b001, 1, 0, 0, 0, 0, 1, 0, 2'b10, 1, 2'b10, 0), "jalr");
      default: ;
    endcase
  endtask

  logic [6:0] pool [10];
  logic [6:0] opc;

  initial begin
    pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
             7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111, 7'b0000000};
    reset     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'b0110011;
    #3;
    check("reset_outputs", 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("first_fetch", v(3'b001, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));

    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, 0, 2);
    run_instr(7'b0100011, 0, 0);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b1111111, 0, 0);
    run_instr(7'b1101111, 1, 0);
    run_instr(7'b1100111, 0, 0);
    run_instr(7'b0110111, 2, 0);

    for (int n = 0; n < 120; n++) begin
      opc = pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) opc = 7'($urandom);
      run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Abort a store while it is waiting on memory.
    drive(7'b0100011, 1'b1, v(3'b001, 0, 1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 0), "fetch");
    drive(7'b0100011, 1'b0, v(3'b001, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "decode");
    drive(7'b0100011, 1'b0, v(3'b001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0), "addr_sw");
    drive(7'b0100011, 1'b0, v(3'b001, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0), "mem_wr");
    @(negedge clk);
    #2;
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset_async", 16'h0000);
    @(posedge clk);
    #1;
    check("reset_hold", 16'h0000);
    reset = 1'b1;
    #1;
    check("post_reset_fetch", v(3'b001, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0100011, 1, 1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
